// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command byte transmitter (inhibit, request-to-send, shift, ACK check).
// Optional single retry after a NACK or timeout when PS2_TX_RETRY_EN is defined.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    input  logic       ps2k_clk,
    input  logic       ps2k_data,
    output logic       ps2k_clk_oe,
    output logic       ps2k_data_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);
    localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, WAIT_IDLE, FAIL} state_t;

    state_t      state;
    logic [2:0]  clk_sync, data_sync;
    logic [7:0]  byte_q;
    logic        parity;
    logic [3:0]  bit_cnt;
    logic [CW-1:0] cnt;
    logic        fe, clk_s, data_s, timeout, last_try;

    assign fe      = clk_sync[2] & ~clk_sync[1];
    assign clk_s   = clk_sync[1];
    assign data_s  = data_sync[1];
    assign timeout = cnt == TMO_LAST;

`ifdef PS2_TX_RETRY_EN
    logic retried;
    assign last_try = retried;
`else
    assign last_try = 1'b1;
`endif

    // Idle bus level is high, so the synchronizers reset to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2k_clk};
            data_sync <= {data_sync[1:0], ps2k_data};
        end
    end

    // A failure raises tx_err on entry to FAIL so the pulse precedes busy dropping by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            byte_q       <= '0;
            parity       <= 1'b0;
            bit_cnt      <= '0;
            cnt          <= '0;
            ps2k_clk_oe  <= 1'b0;
            ps2k_data_oe <= 1'b0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
            tx_err       <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retried      <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            case (state)
                IDLE: begin
`ifdef PS2_TX_RETRY_EN
                    retried <= 1'b0;
`endif
                    if (tx_start) begin
                        byte_q      <= tx_byte;
                        parity      <= ~^tx_byte;
                        cnt         <= '0;
                        ps2k_clk_oe <= 1'b1;
                        tx_busy     <= 1'b1;
                        state       <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        ps2k_data_oe <= 1'b1;
                        state        <= RTS;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RTS: begin
                    ps2k_clk_oe <= 1'b0;
                    bit_cnt     <= '0;
                    cnt         <= '0;
                    state       <= SEND;
                end
                SEND: begin
                    if (fe) begin
                        cnt     <= '0;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (!bit_cnt[3])
                            ps2k_data_oe <= ~byte_q[bit_cnt[2:0]];
                        else if (bit_cnt == 4'd8)
                            ps2k_data_oe <= ~parity;
                        else if (bit_cnt == 4'd9)
                            ps2k_data_oe <= 1'b0;
                        else if (!data_s)
                            state <= WAIT_IDLE;
                        else begin
                            tx_err <= last_try;
                            state  <= FAIL;
                        end
                    end else if (timeout) begin
                        ps2k_data_oe <= 1'b0;
                        tx_err       <= last_try;
                        state        <= FAIL;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_IDLE: begin
                    if (fe)
                        cnt <= '0;
                    else if (clk_s && data_s) begin
                        tx_done <= 1'b1;
                        tx_busy <= 1'b0;
                        state   <= IDLE;
                    end else if (timeout) begin
                        tx_err <= last_try;
                        state  <= FAIL;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                FAIL: begin
                    ps2k_clk_oe  <= 1'b0;
                    ps2k_data_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
                    if (!retried) begin
                        retried     <= 1'b1;
                        cnt         <= '0;
                        ps2k_clk_oe <= 1'b1;
                        state       <= INHIBIT;
                    end else begin
                        tx_busy <= 1'b0;
                        state   <= IDLE;
                    end
`else
                    tx_busy <= 1'b0;
                    state   <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte (for example 0xED set-LEDs, 0xFF reset, 0xF4 enable) from the FPGA to the keyboard over the shared open-drain ps2k_clk/ps2k_data lines. It pairs with the existing keyboard receive path on the same two wires and runs on the 50 MHz system clock. The device generates the bit clock; this block only inhibits, requests-to-send, shifts bits and checks the device ACK.

Parameters:
INHIBIT_CYCLES, 5000, clock-low inhibit time in clk cycles (100 us at 50 MHz).
TIMEOUT_CYCLES, 750000, maximum clk cycles between device clock falling edges after release (15 ms).

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  asynchronous reset, active-high
tx_start  input  1  one-cycle request; sampled only in IDLE
tx_byte  input  8  byte to send; latched on an accepted tx_start
ps2k_clk  input  1  PS/2 clock line, read back
ps2k_data  input  1  PS/2 data line, read back
ps2k_clk_oe  output  1  1 = drive clock line low; 0 = release
ps2k_data_oe  output  1  1 = drive data line low; 0 = release
tx_busy  output  1  high from accepted tx_start until return to IDLE
tx_done  output  1  one-cycle pulse: byte sent and ACK received
tx_err  output  1  one-cycle pulse: NACK or timeout

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: all outputs are 0, both lines are released, FSM is in IDLE. An rst asserted mid-frame releases both lines immediately and does not pulse tx_done or tx_err.
- Input conditioning:
  - ps2k_clk and ps2k_data each pass through a 3-flop synchronizer.
  - Device falling edge (fe) = stage2 high and stage1 low.
  - All line samples use the synchronized values.
- Latch: on an accepted tx_start, store the byte and parity = ~^tx_byte (odd parity).
- FSM:
  - IDLE: both lines released. tx_start goes to INHIBIT; tx_busy rises the next cycle.
  - INHIBIT: clk_oe=1, data_oe=0 for INHIBIT_CYCLES cycles, then go to RTS.
  - RTS: one cycle with clk_oe=1 and data_oe=1 (start bit), then go to SEND.
  - SEND: clk_oe=0 and data_oe held high. bit_cnt starts at 0 and the timeout counter clears. Each fe does the following by bit_cnt:
    - 0..7: data_oe = ~byte[bit_cnt], LSB first.
    - 8: data_oe = ~parity.
    - 9: data_oe = 0 (stop, line released).
    - 10: sample the data line. Low means ACK and goes to WAIT_IDLE; high means NACK and goes to FAIL.
  - WAIT_IDLE: both lines released. Wait until the synchronized clock and data are both high, then pulse tx_done and go to IDLE.
  - FAIL: release both lines, pulse tx_err, go to IDLE.
- Timeout: the counter runs in SEND and WAIT_IDLE and clears on every fe. Reaching TIMEOUT_CYCLES goes to FAIL.
- tx_start while busy is ignored, with no queuing. tx_done and tx_err are never high in the same cycle.
- fe is ignored in IDLE, INHIBIT and RTS.
- The receiver sees device traffic only. Host-driven bits are not this block's concern.

Optional Feature:
PS2_TX_RETRY_EN
- Defined: a failure goes back to INHIBIT once with the same latched byte. tx_busy stays high throughout. tx_err pulses only if the retry also fails. A 1-bit retry flag clears in IDLE.
- Undefined: the first failure pulses tx_err and returns to IDLE.

Test Plan:
1. tx_byte=0xED, device model with 80 us clock period, ACK → data_oe sequence after fe: 0,1,0,0,1,0,0,0, parity 0, stop 0. tx_done pulses once and tx_err stays 0.
2. tx_byte=0x01, INHIBIT_CYCLES=20 → clk_oe high for exactly 20 cycles, then the RTS cycle has both oe=1. Parity bit sent=0, so data_oe=1. ACK gives tx_done.
3. tx_byte=0xFF, device leaves data high on the 11th fe (NACK) → tx_err pulses and both lines are released. With PS2_TX_RETRY_EN and ACK on the retry: a second inhibit follows, then tx_done with no tx_err.
4. tx_start, device never clocks after RTS, TIMEOUT_CYCLES=1000 → tx_err exactly 1000 cycles after SEND entry and tx_busy low the next cycle.
5. tx_start repeated during SEND with tx_byte=0xAA → ignored, original byte 0xED transmitted intact.
6. rst asserted at bit_cnt=4 → ps2k_clk_oe and ps2k_data_oe drop immediately (asynchronously), tx_busy=0, no tx_done or tx_err pulse. A new tx_start after rst is released is accepted.
